// File: rtl/aes_cipher_core.sv
// Iterative AES encryption core: one shared round datapath, one round per clock,
// key schedule supplied pre-expanded and latched when a block is accepted.
module aes_cipher_core #(
    parameter int KEY_BITS = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1919:0] expanded_key,
    input  logic [127:0]  i_data,
    input  logic          i_valid,
    output logic          i_ready,
    output logic [127:0]  o_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic          o_busy
);

    localparam int NR = (KEY_BITS == 256) ? 14 : (KEY_BITS == 192) ? 12 : 10;
    localparam logic [3:0] NR_C = 4'(NR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e           fsm_r;
    logic [3:0]     round_r;
    logic [127:0]   state_r;
    logic [1919:0]  key_r;
    logic [127:0]   o_data_r;
    logic           i_ready_r;
    logic           o_valid_r;
    logic           o_busy_r;
    logic [127:0]   rk_s;
    logic [127:0]   sr_s;
    logic [127:0]   mid_s;
    logic [127:0]   last_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? (p ^ x) : p;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Byte i lives at bits [127-8i -: 8]; row r, column c is byte r+4c
    function automatic logic [127:0] sub_shift(input logic [127:0] st);
        logic [127:0] res;
        res = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127-8*(r+4*c) -: 8] = sbox(st[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] st);
        logic [127:0] res;
        logic [7:0]   a0, a1, a2, a3;
        res = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = st[127-32*c -: 8];
            a1 = st[119-32*c -: 8];
            a2 = st[111-32*c -: 8];
            a3 = st[103-32*c -: 8];
            res[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return res;
    endfunction

    assign rk_s = key_r[11'd1919 - {round_r, 7'd0} -: 128];

    // Shared round datapath: full round and final round (no MixColumns)
    always_comb begin
        sr_s   = sub_shift(state_r);
        mid_s  = mix_columns(sr_s) ^ rk_s;
        last_s = sr_s ^ rk_s;
    end

    // Control FSM, round counter and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r     <= IDLE;
            round_r   <= 4'd0;
            state_r   <= 128'h0;
            o_data_r  <= 128'h0;
            i_ready_r <= 1'b1;
            o_valid_r <= 1'b0;
            o_busy_r  <= 1'b0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (i_valid) begin
                        state_r   <= i_data ^ expanded_key[1919 -: 128];
                        key_r     <= expanded_key;
                        round_r   <= 4'd1;
                        fsm_r     <= RUN;
                        i_ready_r <= 1'b0;
                        o_busy_r  <= 1'b1;
                    end else begin
                        fsm_r <= IDLE;
                    end
                end
                RUN: begin
                    if (round_r >= NR_C) begin
                        o_data_r  <= last_s;
                        fsm_r     <= DONE;
                        o_busy_r  <= 1'b0;
                        o_valid_r <= 1'b1;
                    end else begin
                        state_r <= mid_s;
                        round_r <= round_r + 4'd1;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        fsm_r     <= IDLE;
                        o_valid_r <= 1'b0;
                        i_ready_r <= 1'b1;
                    end else begin
                        fsm_r <= DONE;
                    end
                end
                default: begin
                    fsm_r     <= IDLE;
                    round_r   <= 4'd0;
                    i_ready_r <= 1'b1;
                    o_valid_r <= 1'b0;
                    o_busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign i_ready = i_ready_r;
    assign o_valid = o_valid_r;
    assign o_busy  = o_busy_r;
    assign o_data  = o_data_r;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Bench for aes_cipher_core: three instances (128/192/256-bit keys) checked against
// a byte-array AES reference with its own key expansion and table S-box.
module tb_aes_cipher_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [1919:0]  ek_s;
    logic [127:0]   data_s;
    logic [2:0]     i_valid_s, i_ready_s, o_valid_s, o_ready_s, o_busy_s;
    logic [127:0]   o_data_s [3];

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox_t [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_cipher_core #(.KEY_BITS(128 + 64*g)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .expanded_key (ek_s),
            .i_data       (data_s),
            .i_valid      (i_valid_s[g]),
            .i_ready      (i_ready_s[g]),
            .o_data       (o_data_s[g]),
            .o_valid      (o_valid_s[g]),
            .o_ready      (o_ready_s[g]),
            .o_busy       (o_busy_s[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic int nr_of(input int g);
        return 10 + 2*g;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mulc(input logic [7:0] b, input int m);
        case (m)
            2:       return xt(b);
            3:       return xt(b) ^ b;
            default: return b;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int g, output logic [1919:0] ek);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        int nk, nw;
        nk = 4 + 2*g;
        nw = 4 * (nr_of(g) + 1);
        rc = 8'h01;
        for (int i = 0; i < 60; i++) ek[1919-32*i -: 32] = $urandom;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < nw; i++) ek[1919-32*i -: 32] = w[i];
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [1919:0] ek, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        int m;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ek[1919-8*i -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r+4*c] = t[r + 4*((c+r)%4)];
            if (rnd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) begin
                        t[r+4*c] = 8'h00;
                        for (int k = 0; k < 4; k++) begin
                            m = (k - r + 4) % 4;
                            t[r+4*c] = t[r+4*c] ^ mulc(s[k+4*c], (m == 0) ? 2 : (m == 1) ? 3 : 1);
                        end
                    end
                end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ek[1919-128*rnd-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic rand_key(output logic [255:0] k);
        for (int i = 0; i < 8; i++) k[255-32*i -: 32] = $urandom;
    endtask

    task automatic rand_block(output logic [127:0] b);
        b = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < 60; i++) ek_s[1919-32*i -: 32] = $urandom;
        data_s = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic accept_block(input int g, input logic [127:0] pt, input logic [1919:0] ek);
        ek_s = ek;
        data_s = pt;
        i_valid_s[g] = 1'b1;
        @(posedge clk); #1;
        i_valid_s[g] = 1'b0;
        scramble_inputs();
    endtask

    task automatic wait_done(input int g, output int lat);
        lat = 0;
        while (o_valid_s[g] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out(input int g);
        o_ready_s[g] = 1'b1;
        @(posedge clk); #1;
        o_ready_s[g] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        i_valid_s = 3'b111;
        o_ready_s = 3'b111;
        scramble_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        i_valid_s = 3'b000;
        o_ready_s = 3'b000;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({i_ready_s[g], o_valid_s[g], o_busy_s[g]} !== 3'b100) begin
                errors++;
                $display("FAIL reset_flags g=%0d got rdy/vld/busy=%b want 100", g,
                         {i_ready_s[g], o_valid_s[g], o_busy_s[g]});
            end
            checks++;
            if (o_data_s[g] !== 128'h0) begin
                errors++;
                $display("FAIL reset_data g=%0d got %h want 0", g, o_data_s[g]);
            end
        end
    endtask

    task automatic test_known_answer();
        logic [127:0]  kat [3];
        logic [127:0]  pt, mdl;
        logic [255:0]  key;
        logic [1919:0] ek;
        int lat;
        kat[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        kat[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        kat[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
        pt = 128'h00112233445566778899aabbccddeeff;
        for (int g = 0; g < 3; g++) begin
            key = 256'h0;
            for (int i = 0; i < 16 + 8*g; i++) key[255-8*i -: 8] = 8'(i);
            expand_key(key, g, ek);
            mdl = aes_ref(pt, ek, nr_of(g));
            accept_block(g, pt, ek);
            checks++;
            if ({i_ready_s[g], o_valid_s[g], o_busy_s[g]} !== 3'b001) begin
                errors++;
                $display("FAIL kat_busy g=%0d got rdy/vld/busy=%b want 001", g,
                         {i_ready_s[g], o_valid_s[g], o_busy_s[g]});
            end
            wait_done(g, lat);
            checks++;
            if (lat !== nr_of(g)) begin
                errors++;
                $display("FAIL kat_latency g=%0d got %0d want %0d", g, lat, nr_of(g));
            end
            checks++;
            if (o_data_s[g] !== kat[g]) begin
                errors++;
                $display("FAIL kat_data g=%0d got %h want %h", g, o_data_s[g], kat[g]);
            end
            checks++;
            if (o_data_s[g] !== mdl) begin
                errors++;
                $display("FAIL kat_model g=%0d got %h want %h", g, o_data_s[g], mdl);
            end
            release_out(g);
            checks++;
            if ({i_ready_s[g], o_valid_s[g]} !== 2'b10) begin
                errors++;
                $display("FAIL kat_release g=%0d got rdy/vld=%b want 10", g, {i_ready_s[g], o_valid_s[g]});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [255:0]  key;
        logic [1919:0] ek1, ek2;
        logic [127:0]  pt1, pt2, exp1, exp2;
        int lat;
        for (int g = 0; g < 3; g++) begin
            rand_key(key); expand_key(key, g, ek1); rand_block(pt1);
            rand_key(key); expand_key(key, g, ek2); rand_block(pt2);
            exp1 = aes_ref(pt1, ek1, nr_of(g));
            exp2 = aes_ref(pt2, ek2, nr_of(g));
            accept_block(g, pt1, ek1);
            wait_done(g, lat);
            checks++;
            if (lat !== nr_of(g)) begin
                errors++;
                $display("FAIL bp_latency g=%0d got %0d want %0d", g, lat, nr_of(g));
            end
            for (int c = 0; c < 20; c++) begin
                i_valid_s[g] = 1'b1;
                scramble_inputs();
                @(posedge clk); #1;
                checks++;
                if ({i_ready_s[g], o_valid_s[g], o_busy_s[g]} !== 3'b010) begin
                    errors++;
                    $display("FAIL bp_hold_flags g=%0d cyc=%0d got rdy/vld/busy=%b want 010", g, c,
                             {i_ready_s[g], o_valid_s[g], o_busy_s[g]});
                end
                checks++;
                if (o_data_s[g] !== exp1) begin
                    errors++;
                    $display("FAIL bp_hold_data g=%0d cyc=%0d got %h want %h", g, c, o_data_s[g], exp1);
                end
            end
            ek_s = ek2;
            data_s = pt2;
            o_ready_s[g] = 1'b1;
            @(posedge clk); #1;
            o_ready_s[g] = 1'b0;
            checks++;
            if ({i_ready_s[g], o_valid_s[g]} !== 2'b10) begin
                errors++;
                $display("FAIL bp_return_idle g=%0d got rdy/vld=%b want 10", g, {i_ready_s[g], o_valid_s[g]});
            end
            @(posedge clk); #1;
            i_valid_s[g] = 1'b0;
            scramble_inputs();
            checks++;
            if (o_busy_s[g] !== 1'b1) begin
                errors++;
                $display("FAIL bp_second_accept g=%0d got busy=%b want 1", g, o_busy_s[g]);
            end
            wait_done(g, lat);
            checks++;
            if (lat !== nr_of(g) || o_data_s[g] !== exp2) begin
                errors++;
                $display("FAIL bp_second_block g=%0d got lat=%0d data=%h want lat=%0d data=%h",
                         g, lat, o_data_s[g], nr_of(g), exp2);
            end
            release_out(g);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [255:0]  key;
        logic [1919:0] ek;
        logic [127:0]  pt, expv;
        int lat, seen;
        for (int g = 0; g < 3; g++) begin
            rand_key(key); expand_key(key, g, ek); rand_block(pt);
            accept_block(g, pt, ek);
            repeat (4) @(posedge clk);
            #1;
            rst = 1'b1;
            i_valid_s[g] = 1'b1;
            o_ready_s[g] = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            i_valid_s[g] = 1'b0;
            o_ready_s[g] = 1'b0;
            checks++;
            if ({i_ready_s[g], o_valid_s[g], o_busy_s[g]} !== 3'b100 || o_data_s[g] !== 128'h0) begin
                errors++;
                $display("FAIL midrst_state g=%0d got rdy/vld/busy=%b data=%h want 100 data=0", g,
                         {i_ready_s[g], o_valid_s[g], o_busy_s[g]}, o_data_s[g]);
            end
            seen = 0;
            for (int c = 0; c < nr_of(g) + 2; c++) begin
                @(posedge clk); #1;
                if (o_valid_s[g] === 1'b1) seen++;
            end
            checks++;
            if (seen !== 0) begin
                errors++;
                $display("FAIL midrst_no_valid g=%0d got %0d valid cycles want 0", g, seen);
            end
            rand_key(key); expand_key(key, g, ek); rand_block(pt);
            expv = aes_ref(pt, ek, nr_of(g));
            accept_block(g, pt, ek);
            wait_done(g, lat);
            checks++;
            if (lat !== nr_of(g) || o_data_s[g] !== expv) begin
                errors++;
                $display("FAIL midrst_next_block g=%0d got lat=%0d data=%h want lat=%0d data=%h",
                         g, lat, o_data_s[g], nr_of(g), expv);
            end
            release_out(g);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0]  key;
        logic [1919:0] eks [4];
        logic [127:0]  pts [4];
        logic [127:0]  exps [4];
        logic          prev_ready;
        int n_acc, n_out, last_acc;
        for (int g = 0; g < 3; g++) begin
            for (int b = 0; b < 4; b++) begin
                rand_key(key); expand_key(key, g, eks[b]); rand_block(pts[b]);
                exps[b] = aes_ref(pts[b], eks[b], nr_of(g));
            end
            n_acc = 0; n_out = 0; last_acc = 0;
            ek_s = eks[0];
            data_s = pts[0];
            o_ready_s[g] = 1'b1;
            i_valid_s[g] = 1'b1;
            prev_ready = i_ready_s[g];
            for (int cyc = 1; cyc <= 200 && n_out < 4; cyc++) begin
                @(posedge clk); #1;
                if (prev_ready && n_acc < 4) begin
                    if (n_acc > 0) begin
                        checks++;
                        if (cyc - last_acc !== nr_of(g) + 2) begin
                            errors++;
                            $display("FAIL b2b_interval g=%0d blk=%0d got %0d want %0d", g, n_acc,
                                     cyc - last_acc, nr_of(g) + 2);
                        end
                    end
                    last_acc = cyc;
                    n_acc++;
                    if (n_acc < 4) begin
                        ek_s = eks[n_acc];
                        data_s = pts[n_acc];
                    end else begin
                        i_valid_s[g] = 1'b0;
                        scramble_inputs();
                    end
                end
                if (o_valid_s[g] === 1'b1 && n_out < 4) begin
                    checks++;
                    if (o_data_s[g] !== exps[n_out]) begin
                        errors++;
                        $display("FAIL b2b_data g=%0d blk=%0d got %h want %h", g, n_out, o_data_s[g], exps[n_out]);
                    end
                    n_out++;
                end
                prev_ready = i_ready_s[g];
            end
            @(posedge clk); #1;
            i_valid_s[g] = 1'b0;
            o_ready_s[g] = 1'b0;
            checks++;
            if (n_out !== 4) begin
                errors++;
                $display("FAIL b2b_count g=%0d got %0d outputs want 4", g, n_out);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_known_answer();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_cipher_core.md
AES_CIPHER_CORE -- requirements
Module: aes_cipher_core

Interface
REQ-001 The block SHALL have parameter KEY_BITS, default 128, selecting the AES key size; legal values are 128, 192 and 256.
REQ-002 The block SHALL derive localparam NR = 10, 12 or 14 from KEY_BITS = 128, 192 or 256.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port expanded_key  input  1920  round keys packed MSB-first: round k key = expanded_key[1919-128k -: 128]; bits beyond round NR are ignored.
REQ-006 The block SHALL have port i_data  input  128  plaintext block, byte 0 at bits [127:120].
REQ-007 The block SHALL have port i_valid  input  1  plaintext and key present.
REQ-008 The block SHALL have port i_ready  output  1  block can accept a new plaintext.
REQ-009 The block SHALL have port o_data  output  128  ciphertext, same byte order as i_data.
REQ-010 The block SHALL have port o_valid  output  1  o_data holds a completed ciphertext.
REQ-011 The block SHALL have port o_ready  input  1  consumer accepts o_data.
REQ-012 The block SHALL have port o_busy  output  1  a block is in the round loop.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-014 i_ready SHALL equal (state == IDLE); o_valid SHALL equal (state == DONE); o_busy SHALL equal (state == RUN).
REQ-015 Acceptance SHALL occur on an edge where i_valid and i_ready are both high.
REQ-016 On acceptance: the block SHALL register state <= i_data XOR round key 0, latch all 1920 key bits internally, load round <= 1, and go to RUN.
REQ-017 After acceptance, changes on expanded_key or i_data SHALL NOT affect the block in flight.
REQ-018 In RUN with round < NR, each edge SHALL do state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), key[round]) and round <= round + 1.
REQ-019 In RUN with round == NR, the edge SHALL do o_data <= AddRoundKey(ShiftRows(SubBytes(state)), key[NR]) and go to DONE; MixColumns SHALL be omitted.
REQ-020 Latency SHALL be exactly NR cycles: o_valid rises NR edges after the acceptance edge (10/12/14).
REQ-021 The round counter SHALL be 4 bits wide, SHALL never exceed NR, and SHALL NOT wrap.
REQ-022 In DONE, o_data and o_valid SHALL hold stable until an edge with o_ready high; that edge SHALL return the FSM to IDLE.
REQ-023 Back-pressure of any length SHALL NOT corrupt o_data.
REQ-024 The block SHALL NOT accept new input in DONE; i_valid held high SHALL be accepted on the first edge in IDLE.
REQ-025 Maximum throughput SHALL be one block per NR+2 cycles.
REQ-026 i_valid in RUN or DONE SHALL be ignored, with no state change.
REQ-027 o_ready outside DONE SHALL be ignored.
REQ-028 SubBytes SHALL use the FIPS-197 S-box combinationally, 16 instances, in a single round datapath shared across rounds.

Reset
REQ-029 When rst is high at an edge, the block SHALL go to IDLE, set round <= 0, state <= 0 and o_data <= 0, and clear o_valid and o_busy; i_ready SHALL be 1 after that edge.
REQ-030 rst SHALL take priority over every handshake, including a simultaneous i_valid or o_ready.
REQ-031 rst mid-RUN or mid-DONE SHALL discard the block in flight, with no o_valid pulse.
REQ-032 Latched key contents after reset SHALL be don't-care.

Verification
REQ-033 Scenario 1: KEY_BITS=128, key 000102..0f expanded, pt 00112233445566778899aabbccddeeff -> o_valid exactly 10 cycles after acceptance, o_data 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-034 Scenario 2: KEY_BITS=192, key 00..17, same pt -> o_data dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles.
REQ-035 Scenario 3: KEY_BITS=256, key 00..1f, same pt -> o_data 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
REQ-036 Scenario 4: hold o_ready low 20 cycles after o_valid while driving new i_valid and changing expanded_key -> o_data unchanged, i_ready 0; once o_ready is high, the FSM returns to IDLE and the second block is accepted the next edge.
REQ-037 Scenario 5: assert rst at round 5 -> next cycle i_ready 1, o_valid 0, o_data 0; a following block completes correctly with full latency.
REQ-038 Scenario 6: back-to-back blocks with o_ready tied high -> one acceptance every NR+2 cycles, and each ciphertext matches the reference model.
